random_request_generator: RTL and testbench
===========================================

Name: random_request_generator

Overview:
Downstream consumer of RandomGenerator. It turns the RNG's stream of random words into a bounded sequence of random read/write memory requests for the memory-controller under test. It drives the RNG enable, samples one random word per field (command, address, data), and presents each request on a valid/ready interface toward the controller front-end. A top-level traffic bench instantiates it beside RandomGenerator.

Parameters:
WIDTH, 32, random word width; must equal RandomGenerator WIDTH
ADDR_WIDTH, 32, request address width (ADDR_WIDTH <= WIDTH)
DATA_WIDTH, 32, write data width (DATA_WIDTH <= WIDTH)
ALIGN_BITS, 2, address LSBs forced to zero (byte alignment 2^ALIGN_BITS)
COUNT_WIDTH, 16, width of request counters

Ports:
in_clock  input  1  clock, all logic on rising edge
in_reset_n  input  1  asynchronous active-low reset
in_start  input  1  start pulse, sampled only in IDLE
in_stop  input  1  stop request, finishes the in-flight handshake then stops
in_num_requests  input  COUNT_WIDTH  requests per run; 0 = run until in_stop
in_write_thresh  input  9  write if {1'b0,rand[7:0]} < thresh; 0 = all reads, 256 = all writes
in_addr_base  input  ADDR_WIDTH  address base, ORed in
in_addr_mask  input  ADDR_WIDTH  random address bits kept
in_random  input  WIDTH  out_random from RandomGenerator
out_rng_enable  output  1  to RandomGenerator in_enable
out_req_valid  output  1  request valid
in_req_ready  input  1  controller accepts request
out_req_write  output  1  1 = write, 0 = read
out_req_addr  output  ADDR_WIDTH  request address
out_req_wdata  output  DATA_WIDTH  write data; 0 for reads
out_busy  output  1  high outside IDLE
out_done  output  1  one-cycle pulse at run end
out_req_count  output  COUNT_WIDTH  accepted primary requests this run

Behaviour:
- Reset (async, n=0): state IDLE. All outputs 0, counters 0. Takes effect mid-handshake; the in-flight request is dropped.
- States: IDLE, GEN_CMD, GEN_ADDR, GEN_DATA, ISSUE, DONE.
- IDLE: in_start=1 -> GEN_CMD. Clear out_req_count. in_start outside IDLE is ignored.
- out_rng_enable=1 exactly in GEN_CMD, GEN_ADDR and GEN_DATA. Each of these states samples in_random once at its closing edge.
- GEN_CMD: write = ({1'b0,in_random[7:0]} < in_write_thresh). Next state is GEN_ADDR.
- GEN_ADDR: addr = (in_addr_base | (in_random[ADDR_WIDTH-1:0] & in_addr_mask)), with [ALIGN_BITS-1:0] forced to 0. Next state is GEN_DATA if write, else ISSUE with wdata=0.
- GEN_DATA: wdata = in_random[DATA_WIDTH-1:0]. Next state is ISSUE.
- Latency: start accepted at edge N. A write shows valid after edge N+4; a read shows valid after edge N+3.
- ISSUE: out_req_valid=1. write/addr/wdata are registered and stable until accepted. Valid never drops without ready.
- ISSUE, on valid&ready: increment out_req_count (saturates at all-ones).
  - -> DONE if stop is pending, or if in_num_requests!=0 and the new count == in_num_requests.
  - Otherwise -> GEN_CMD with zero bubble beyond the generate states.
- in_stop: sets a sticky stop_pending in any non-IDLE state.
  - In a GEN state: abandon generation -> DONE. No valid is ever raised.
  - In ISSUE: complete the handshake first.
  - stop_pending clears in IDLE.
- DONE: out_done=1 for one cycle -> IDLE. out_busy=0 in IDLE only.
- in_num_requests is sampled at start. Changes mid-run are ignored.

Optional Feature:
RAND_REQ_READBACK_EN.
- Defined: after each accepted write, state READBACK issues a read to the same addr with wdata=0. It follows the same valid/ready rules. The readback is not counted in out_req_count and does not count toward in_num_requests. A stop pending during READBACK waits for its handshake. The run ends only after the readback completes.
- Undefined: the READBACK state and its logic are absent.

Decomposition:
- Package rand_req_pkg:
  - state enum (including READBACK, encoded always)
  - CMD_READ=1'b0, CMD_WRITE=1'b1
  - WRITE_THRESH_WIDTH=9, THRESH_ALWAYS=9'd256
- No sub-module needed. The RNG stays a sibling instance wired at the traffic top. The field-mapping logic is small and stays inline.

Test Plan:
1. Bench drives in_random sequence 0x05, 0x1234, 0xDEADBEEF. Settings: thresh=128, base=0x1000, mask=0x0FFF, num=1. -> One write, addr 0x1234, wdata 0xDEADBEEF, valid after edge N+4, then out_done pulse, out_req_count=1.
2. Same setup with in_random first word 0xC8 (200 >= 128). -> Read at addr 0x1234 with wdata=0, valid after edge N+3. out_rng_enable high for exactly 2 cycles.
3. in_req_ready held low for 10 cycles during ISSUE. -> valid/addr/wdata/write stable for all 10 cycles. Count increments only on the handshake cycle.
4. num=0, ready=1. Assert in_stop during GEN_ADDR of request 5. -> No 5th valid, out_done pulses, out_req_count=4. A second in_stop pulse sent during ISSUE completes that request first.
5. Drop in_reset_n to 0 mid-ISSUE. -> All outputs 0 asynchronously. After release, in_start begins a fresh run with count 0.
6. With RAND_REQ_READBACK_EN, thresh=256, num=2. -> Accepted request sequence W(a0), R(a0), W(a1), R(a1). out_req_count=2. out_done only after the second read is accepted.

Source files
------------

// File: rtl/random_request_generator_pkg.sv
// rand_req_pkg: shared state encoding and command constants for random_request_generator
package rand_req_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GEN_CMD  = 3'd1,
        S_GEN_ADDR = 3'd2,
        S_GEN_DATA = 3'd3,
        S_ISSUE    = 3'd4,
        S_DONE     = 3'd5,
        S_READBACK = 3'd6
    } state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int WRITE_THRESH_WIDTH = 9;
    localparam logic [WRITE_THRESH_WIDTH-1:0] THRESH_ALWAYS = 9'd256;

endpackage

// File: rtl/random_request_generator.sv
// random_request_generator: turns RNG words into a bounded stream of random read/write
// requests on a valid/ready interface. Optional macro RAND_REQ_READBACK_EN adds a
// read-back of every accepted write to the same address.
module random_request_generator
    import rand_req_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ALIGN_BITS  = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                          in_clock,
    input  logic                          in_reset_n,
    input  logic                          in_start,
    input  logic                          in_stop,
    input  logic [COUNT_WIDTH-1:0]        in_num_requests,
    input  logic [WRITE_THRESH_WIDTH-1:0] in_write_thresh,
    input  logic [ADDR_WIDTH-1:0]         in_addr_base,
    input  logic [ADDR_WIDTH-1:0]         in_addr_mask,
    input  logic [WIDTH-1:0]              in_random,
    output logic                          out_rng_enable,
    output logic                          out_req_valid,
    input  logic                          in_req_ready,
    output logic                          out_req_write,
    output logic [ADDR_WIDTH-1:0]         out_req_addr,
    output logic [DATA_WIDTH-1:0]         out_req_wdata,
    output logic                          out_busy,
    output logic                          out_done,
    output logic [COUNT_WIDTH-1:0]        out_req_count
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << ALIGN_BITS) - ADDR_WIDTH'(1));

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_start;
    logic                    r_stop_pending;
    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic [COUNT_WIDTH-1:0]  r_num;
    logic                    w_stop;
    logic                    w_hs;
    logic                    w_accept;
    logic                    w_last;
    logic [COUNT_WIDTH-1:0]  w_count_inc;

    assign out_rng_enable = (r_state == S_GEN_CMD) || (r_state == S_GEN_ADDR) || (r_state == S_GEN_DATA);
`ifdef RAND_REQ_READBACK_EN
    assign out_req_valid  = (r_state == S_ISSUE) || (r_state == S_READBACK);
`else
    assign out_req_valid  = (r_state == S_ISSUE);
`endif
    assign out_req_write  = r_write;
    assign out_req_addr   = r_addr;
    assign out_req_wdata  = r_wdata;
    assign out_busy       = (r_state != S_IDLE);
    assign out_done       = (r_state == S_DONE);
    assign out_req_count  = r_count;

    // start is registered in IDLE first, so a run begins one edge after it is accepted
    assign w_accept    = (r_state == S_IDLE) && !r_start && in_start;
    assign w_stop      = r_stop_pending || in_stop;
    assign w_hs        = out_req_valid && in_req_ready;
    assign w_count_inc = (&r_count) ? r_count : r_count + COUNT_WIDTH'(1);
    assign w_last      = (r_num != '0) && (w_count_inc == r_num);

    // state register
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // next-state: stop abandons generation but never cuts an in-flight handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = r_start ? S_GEN_CMD : S_IDLE;
            S_GEN_CMD:  w_next = w_stop ? S_DONE : S_GEN_ADDR;
            S_GEN_ADDR: w_next = w_stop ? S_DONE : (r_write ? S_GEN_DATA : S_ISSUE);
            S_GEN_DATA: w_next = w_stop ? S_DONE : S_ISSUE;
`ifdef RAND_REQ_READBACK_EN
            S_ISSUE:    if (w_hs) w_next = r_write ? S_READBACK : ((w_stop || w_last) ? S_DONE : S_GEN_CMD);
            S_READBACK: if (w_hs) w_next = (w_stop || ((r_num != '0) && (r_count == r_num))) ? S_DONE : S_GEN_CMD;
`else
            S_ISSUE:    if (w_hs) w_next = (w_stop || w_last) ? S_DONE : S_GEN_CMD;
`endif
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // request fields, counters and sticky stop
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_start        <= 1'b0;
            r_stop_pending <= 1'b0;
            r_write        <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_count        <= '0;
            r_num          <= '0;
        end else begin
            r_start        <= w_accept;
            r_stop_pending <= (r_state == S_IDLE) ? 1'b0 : w_stop;
            if (w_accept) begin
                r_count <= '0;
                r_num   <= in_num_requests;
            end
            if (r_state == S_GEN_CMD)
                r_write <= ({1'b0, in_random[7:0]} < in_write_thresh) ? CMD_WRITE : CMD_READ;
            if (r_state == S_GEN_ADDR) begin
                r_addr <= (in_addr_base | (in_random[ADDR_WIDTH-1:0] & in_addr_mask)) & ALIGN_MASK;
                if (!r_write) r_wdata <= '0;
            end
            if (r_state == S_GEN_DATA) r_wdata <= in_random[DATA_WIDTH-1:0];
            if ((r_state == S_ISSUE) && w_hs) begin
                r_count <= w_count_inc;
`ifdef RAND_REQ_READBACK_EN
                if (r_write) begin
                    r_write <= CMD_READ;
                    r_wdata <= '0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_random_request_generator.sv
// tb_random_request_generator: directed checks of random_request_generator (readback run with RAND_REQ_READBACK_EN)
module tb_random_request_generator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] num;
    logic [8:0]  thresh;
    logic [31:0] base;
    logic [31:0] mask;
    logic [31:0] rnd;
    logic        rng_en;
    logic        valid;
    logic        ready;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [15:0] count;
    int          tests = 0;
    int          fails = 0;

    random_request_generator dut (
        .in_clock        (clk),
        .in_reset_n      (rst_n),
        .in_start        (start),
        .in_stop         (stop),
        .in_num_requests (num),
        .in_write_thresh (thresh),
        .in_addr_base    (base),
        .in_addr_mask    (mask),
        .in_random       (rnd),
        .out_rng_enable  (rng_en),
        .out_req_valid   (valid),
        .in_req_ready    (ready),
        .out_req_write   (wr),
        .out_req_addr    (addr),
        .out_req_wdata   (wdata),
        .out_busy        (busy),
        .out_done        (done),
        .out_req_count   (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int w;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; num = 16'd1; thresh = 9'd128;
        base = 32'h1000; mask = 32'h0FFF; rnd = '0; ready = 1'b1;
        step;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rng", 32'(rng_en), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_addr", addr, 0);
        rst_n = 1'b1;
        step;

        // write request: latency N+4, then done with count 1
        start = 1'b1; step; start = 1'b0;
        chk("t1_rng_n", 32'(rng_en), 0);
        chk("t1_busy_n", 32'(busy), 0);
        step; chk("t1_rng_cmd", 32'(rng_en), 1); chk("t1_busy", 32'(busy), 1); rnd = 32'h05;
        step; chk("t1_rng_addr", 32'(rng_en), 1); rnd = 32'h1234;
        step; chk("t1_rng_data", 32'(rng_en), 1); chk("t1_valid_n3", 32'(valid), 0); rnd = 32'hDEADBEEF;
        step;
        chk("t1_valid", 32'(valid), 1);
        chk("t1_rng_issue", 32'(rng_en), 0);
        chk("t1_write", 32'(wr), 1);
        chk("t1_addr", addr, 32'h1234);
        chk("t1_wdata", wdata, 32'hDEADBEEF);
        chk("t1_count0", 32'(count), 0);
        step;
        chk("t1_done", 32'(done), 1);
        chk("t1_count", 32'(count), 1);
        chk("t1_valid_off", 32'(valid), 0);
        step;
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_idle", 32'(busy), 0);

        // read request with ready held low for 10 cycles
        ready = 1'b0;
        start = 1'b1; step; start = 1'b0;
        chk("t2_rng_n", 32'(rng_en), 0);
        step; chk("t2_rng_cmd", 32'(rng_en), 1); rnd = 32'hC8;
        step; chk("t2_rng_addr", 32'(rng_en), 1); rnd = 32'h1234;
        step;
        chk("t2_rng_issue", 32'(rng_en), 0);
        for (int i = 0; i < 10; i++) begin
            chk("t3_valid", 32'(valid), 1);
            chk("t3_write", 32'(wr), 0);
            chk("t3_addr", addr, 32'h1234);
            chk("t3_wdata", wdata, 0);
            chk("t3_count", 32'(count), 0);
            step;
        end
        ready = 1'b1;
        chk("t3_valid_last", 32'(valid), 1);
        step;
        chk("t3_done", 32'(done), 1);
        chk("t3_count_hs", 32'(count), 1);
        step;

        // unbounded run stopped during GEN_ADDR of request 5
        num = 16'd0; thresh = 9'd0; rnd = 32'h55;
        start = 1'b1; step; start = 1'b0;
        step(3);
        chk("t4_valid1", 32'(valid), 1);
        chk("t4_addr_align", addr, 32'h1054);
        chk("t4_read", 32'(wr), 0);
        w = 0;
        while (count != 16'd4 && w < 60) begin step; w++; end
        chk("t4_reach4", 32'(w < 60), 1);
        chk("t4_gencmd5", 32'(rng_en), 1);
        step;
        chk("t4_genaddr5", 32'(rng_en), 1);
        stop = 1'b1; step; stop = 1'b0;
        chk("t4_done", 32'(done), 1);
        chk("t4_no_valid", 32'(valid), 0);
        chk("t4_count", 32'(count), 4);
        step;
        chk("t4_idle", 32'(busy), 0);

        // stop during ISSUE completes the handshake first
        ready = 1'b0;
        start = 1'b1; step; start = 1'b0;
        step(3);
        chk("t4b_valid", 32'(valid), 1);
        stop = 1'b1; step; stop = 1'b0;
        chk("t4b_hold_valid", 32'(valid), 1);
        chk("t4b_no_done", 32'(done), 0);
        step;
        chk("t4b_hold_valid2", 32'(valid), 1);
        ready = 1'b1; step;
        chk("t4b_done", 32'(done), 1);
        chk("t4b_count", 32'(count), 1);
        step;

        // asynchronous reset in the middle of a handshake
        start = 1'b1; step; start = 1'b0;
        w = 0;
        while (count != 16'd2 && w < 30) begin step; w++; end
        chk("t5_reach2", 32'(w < 30), 1);
        ready = 1'b0;
        w = 0;
        while (!valid && w < 10) begin step; w++; end
        chk("t5_issue", 32'(valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_count", 32'(count), 0);
        chk("t5_addr", addr, 0);
        @(negedge clk) rst_n = 1'b1;
        num = 16'd1; ready = 1'b1;
        step;
        start = 1'b1; step; start = 1'b0;
        chk("t5_fresh_count", 32'(count), 0);
        step(3);
        chk("t5_fresh_valid", 32'(valid), 1);
        step;
        chk("t5_fresh_done", 32'(done), 1);
        chk("t5_fresh_cnt1", 32'(count), 1);
        step;

`ifdef RAND_REQ_READBACK_EN
        begin
            logic [31:0] seq [6];
            logic [31:0] aa [4];
            logic [31:0] ad [4];
            logic        aw [4];
            int          ri;
            int          acc;
            logic        seen;
            logic [15:0] cnt_at_done;
            seq[0] = 32'h0; seq[1] = 32'h10; seq[2] = 32'h11111111;
            seq[3] = 32'h0; seq[4] = 32'h20; seq[5] = 32'h22222222;
            ri = 0; acc = 0; seen = 1'b0; cnt_at_done = '0;
            thresh = 9'd256; num = 16'd2; ready = 1'b1;
            start = 1'b1; step; start = 1'b0;
            for (int c = 0; c < 60 && !seen; c++) begin
                if (done) begin
                    seen = 1'b1;
                    cnt_at_done = count;
                end
                if (rng_en && ri < 6) begin rnd = seq[ri]; ri++; end
                if (valid && acc < 4) begin
                    aw[acc] = wr; aa[acc] = addr; ad[acc] = wdata; acc++;
                end
                if (!seen) step;
            end
            chk("t6_done_seen", 32'(seen), 1);
            chk("t6_accepted", acc, 4);
            chk("t6_count", 32'(cnt_at_done), 2);
            chk("t6_w0", 32'(aw[0]), 1); chk("t6_a0", aa[0], 32'h1010); chk("t6_d0", ad[0], 32'h11111111);
            chk("t6_w1", 32'(aw[1]), 0); chk("t6_a1", aa[1], 32'h1010); chk("t6_d1", ad[1], 0);
            chk("t6_w2", 32'(aw[2]), 1); chk("t6_a2", aa[2], 32'h1020); chk("t6_d2", ad[2], 32'h22222222);
            chk("t6_w3", 32'(aw[3]), 0); chk("t6_a3", aa[3], 32'h1020); chk("t6_d3", ad[3], 0);
            step;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
